dac_wave_counter: RTL

DAC_WAVE_COUNTER -- requirements
Module: dac_wave_counter

---
 rtl/dac_wave_counter.sv | 86 ++++++++
 1 files changed

// File: rtl/dac_wave_counter.sv
// dac_wave_counter: sawtooth/triangle/square/hold DAC code generator with period pulse.
// Optional DAC_LIMIT_EN adds a runtime limit port that sets the full-scale value.
module dac_wave_counter #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clear,
  input  logic [1:0]        mode,
  input  logic [STEP_W-1:0] step,
`ifdef DAC_LIMIT_EN
  input  logic [WIDTH-1:0]  limit,
`endif
  output logic [WIDTH-1:0]  dacCount,
  output logic              dir,
  output logic              period_done
);
  logic [1:0]       r_mode;
  logic [WIDTH-1:0] r_phase;
  logic [WIDTH:0]   w_maxv, w_step, w_up, w_dn, w_ph;
  logic [WIDTH-1:0] w_cnt_n, w_ph_n;
  logic             w_dir_n, w_pd_n, w_restart, w_adv;
`ifdef DAC_LIMIT_EN
  assign w_maxv = {1'b0, limit};
`else
  assign w_maxv = {1'b0, {WIDTH{1'b1}}};
`endif
  // One extra bit on every sum so overflow is compared, never wrapped
  assign w_step    = {{(WIDTH+1-STEP_W){1'b0}}, step};
  assign w_up      = {1'b0, dacCount} + w_step;
  assign w_dn      = {1'b0, dacCount} - w_step;
  assign w_ph      = {1'b0, r_phase} + w_step;
  assign w_restart = (mode != r_mode) || clear;
  assign w_adv     = en && (step != '0) && (r_mode != 2'b11);
  always_comb begin
    w_cnt_n = dacCount;
    w_dir_n = dir;
    w_ph_n  = r_phase;
    w_pd_n  = 1'b0;
    if (w_restart) begin
      w_cnt_n = (mode == 2'b10) ? w_maxv[WIDTH-1:0] : '0;
      w_dir_n = 1'b0;
      w_ph_n  = '0;
    end else if (w_adv) begin
      case (r_mode)
        2'b00: begin
          w_pd_n  = w_up > w_maxv;
          w_cnt_n = w_pd_n ? '0 : w_up[WIDTH-1:0];
        end
        2'b01: begin
          if (!dir) begin
            w_dir_n = w_up >= w_maxv;
            w_cnt_n = w_dir_n ? w_maxv[WIDTH-1:0] : w_up[WIDTH-1:0];
          end else begin
            w_pd_n  = {1'b0, dacCount} <= w_step;
            w_dir_n = !w_pd_n;
            w_cnt_n = w_pd_n ? '0 : w_dn[WIDTH-1:0];
          end
        end
        2'b10: begin
          w_ph_n  = w_ph[WIDTH-1:0];
          w_pd_n  = w_ph[WIDTH];
          w_cnt_n = w_ph[WIDTH-1] ? '0 : w_maxv[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode      <= 2'b00;
      r_phase     <= '0;
      dacCount    <= '0;
      dir         <= 1'b0;
      period_done <= 1'b0;
    end else begin
      r_mode      <= mode;
      r_phase     <= w_ph_n;
      dacCount    <= w_cnt_n;
      dir         <= w_dir_n;
      period_done <= w_pd_n;
    end
  end
endmodule
